// File: rtl/histogram_sched.sv
// histogram_sched -- 256-bin histogram of an 8-bit image held in an external RAM.
// Flow: IDLE -> CLEAR (zero all bins) -> ACCUM (stream pixels) -> DRAIN -> DONE.
// The pixel pipeline has three stages: S0 issues the image address, S1 takes the
// returned pixel and reads its bin, S2 writes bin+1 back.
// Build option: define HIST_FWD_EN to forward the in-flight bin value when two
// back-to-back pixels hit the same bin; without it the pipeline stalls one cycle.
module histogram_sched #(
  parameter int N_PIXELS = 4096,
  parameter int BIN_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [11:0]      arg_0_raddr_0,
  input  logic [7:0]       arg_0_rdata_0,
  output logic [7:0]       arg_1_raddr_0,
  input  logic [BIN_W-1:0] arg_1_rdata_0,
  output logic [7:0]       arg_1_waddr_0,
  output logic [BIN_W-1:0] arg_1_wdata_0,
  output logic             arg_1_wen_0,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ACCUM = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [11:0]      LAST_IDX = 12'(N_PIXELS - 1);
  localparam logic [BIN_W-1:0] BIN_ONE  = {{(BIN_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic             busy_r, busy_s;
  logic             valid_r, valid_s;
  logic [7:0]       clr_r;
  logic [11:0]      idx_r;
  logic             s1_v_r, s1_hold_r;
  logic [7:0]       p1_r;
  logic             s2_v_r;
  logic [7:0]       p2_r;
  logic [7:0]       raddr1_r, waddr_r;
  logic [BIN_W-1:0] wdata_r;
  logic [15:0]      stall_cnt_r;

  logic [7:0]       s1_px_s;
  logic             hazard_s, stall_s, issue_s, enter_clear_s;
  logic             s1_v_s, s2_v_s;
  logic [BIN_W-1:0] bin_s;
  logic             wen_s;
  logic [7:0]       waddr_s;
  logic [BIN_W-1:0] wdata_s;

  // Pipeline control: S1 pixel source, same-bin hazard, S0 issue and stage-valid next values
  always_comb begin
    s1_px_s = arg_0_rdata_0;
    if (s1_hold_r) begin
      s1_px_s = p1_r;
    end else begin
      s1_px_s = arg_0_rdata_0;
    end
    // S1's bin read is sampled in the same cycle S2 writes: same bin means stale data
    hazard_s = s1_v_r && s2_v_r && (s1_px_s == p2_r);
`ifdef HIST_FWD_EN
    stall_s = 1'b0;
`else
    stall_s = hazard_s;
`endif
    issue_s       = (state_r == ST_ACCUM) && !stall_s;
    enter_clear_s = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && start;
    if (issue_s) begin
      s1_v_s = 1'b1;
    end else if (stall_s) begin
      s1_v_s = s1_v_r;
    end else begin
      s1_v_s = 1'b0;
    end
    s2_v_s = s1_v_r && !stall_s;
  end

`ifdef HIST_FWD_EN
  logic fwd_r;

  // Remember that the pixel now entering S2 collided with the write just made
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_r <= 1'b0;
    end else begin
      fwd_r <= hazard_s;
    end
  end

  // Bin value for S2: forwarded older write on a collision, else the RAM data
  always_comb begin
    bin_s = arg_1_rdata_0;
    if (fwd_r) begin
      bin_s = wdata_r;
    end else begin
      bin_s = arg_1_rdata_0;
    end
  end
`else
  // Bin value for S2 always comes from the RAM (collisions are stalled away)
  always_comb begin
    bin_s = arg_1_rdata_0;
  end
`endif

  // Bin write port: clearing sweep, S2 increment, or idle with the last values held
  always_comb begin
    wen_s   = 1'b0;
    waddr_s = waddr_r;
    wdata_s = wdata_r;
    if (state_r == ST_CLEAR) begin
      wen_s   = 1'b1;
      waddr_s = clr_r;
      wdata_s = {BIN_W{1'b0}};
    end else if (s2_v_r) begin
      wen_s   = 1'b1;
      waddr_s = p2_r;
      wdata_s = bin_s + BIN_ONE;
    end else begin
      wen_s   = 1'b0;
      waddr_s = waddr_r;
      wdata_s = wdata_r;
    end
  end

  // Next-state and registered status flags
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_CLEAR;
        else       state_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (clr_r == 8'hFF) state_s = ST_ACCUM;
        else                state_s = ST_CLEAR;
      end
      ST_ACCUM: begin
        if (issue_s && (idx_r == LAST_IDX)) state_s = ST_DRAIN;
        else                                state_s = ST_ACCUM;
      end
      ST_DRAIN: begin
        if (!s1_v_s && !s2_v_s) state_s = ST_DONE;
        else                    state_s = ST_DRAIN;
      end
      ST_DONE: begin
        if (start) state_s = ST_CLEAR;
        else       state_s = ST_DONE;
      end
      default: state_s = ST_IDLE;
    endcase
    busy_s  = (state_s == ST_CLEAR) || (state_s == ST_ACCUM) || (state_s == ST_DRAIN);
    valid_s = (state_s == ST_DONE);
  end

  // State register with registered busy/valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= busy_s;
      valid_r <= valid_s;
    end
  end

  // Counters, pipeline stage registers and output hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_r       <= 8'd0;
      idx_r       <= 12'd0;
      s1_v_r      <= 1'b0;
      s1_hold_r   <= 1'b0;
      p1_r        <= 8'd0;
      s2_v_r      <= 1'b0;
      p2_r        <= 8'd0;
      raddr1_r    <= 8'd0;
      waddr_r     <= 8'd0;
      wdata_r     <= {BIN_W{1'b0}};
      stall_cnt_r <= 16'd0;
    end else begin
      if (enter_clear_s) clr_r <= 8'd0;
      else if (state_r == ST_CLEAR) clr_r <= clr_r + 8'd1;
      // Image address starts at 0 with ACCUM and otherwise holds its last value
      if ((state_r == ST_CLEAR) && (clr_r == 8'hFF)) idx_r <= 12'd0;
      else if (issue_s && (idx_r != LAST_IDX)) idx_r <= idx_r + 12'd1;
      s1_v_r    <= s1_v_s;
      // On a stall the pixel must be kept: the image RAM has moved on
      s1_hold_r <= stall_s;
      if (stall_s) p1_r <= s1_px_s;
      s2_v_r <= s2_v_s;
      if (s2_v_s) p2_r <= s1_px_s;
      if (s1_v_r) raddr1_r <= s1_px_s;
      if (wen_s) begin
        waddr_r <= waddr_s;
        wdata_r <= wdata_s;
      end
      if (enter_clear_s) stall_cnt_r <= 16'd0;
      else if (stall_s && (stall_cnt_r != 16'hFFFF)) stall_cnt_r <= stall_cnt_r + 16'd1;
    end
  end

  assign busy          = busy_r;
  assign valid         = valid_r;
  assign arg_0_raddr_0 = idx_r;
  // The bin read must reach the RAM in the cycle the pixel arrives
  assign arg_1_raddr_0 = s1_v_r ? s1_px_s : raddr1_r;
  assign arg_1_wen_0   = wen_s;
  assign arg_1_waddr_0 = waddr_s;
  assign arg_1_wdata_0 = wdata_s;
  assign stall_cnt     = stall_cnt_r;

endmodule

// File: tb/tb_histogram_sched.sv
// Bench for histogram_sched: a 4096-pixel and a 4-pixel instance with RAM models;
// expected histograms, stall counts and run lengths come from a plain model.
module tb_histogram_sched;
  localparam int BW = 32;
  localparam int NB = 4096;
  localparam int NS = 4;
`ifdef HIST_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic          rst_bg, start_bg, busy_bg, valid_bg, we_bg;
  logic [11:0]   ra0_bg;
  logic [7:0]    rd0_bg, ra1_bg, wa_bg;
  logic [BW-1:0] rd1_bg, wd_bg;
  logic [15:0]   sc_bg;
  logic          rst_sm, start_sm, busy_sm, valid_sm, we_sm;
  logic [11:0]   ra0_sm;
  logic [7:0]    rd0_sm, ra1_sm, wa_sm;
  logic [BW-1:0] rd1_sm, wd_sm;
  logic [15:0]   sc_sm;
  logic          pre_sm;
  logic          sel_big;

  logic [7:0]    img_bg [0:NB-1];
  logic [BW-1:0] bins_bg [0:255];
  logic [7:0]    img_sm [0:NS-1];
  logic [BW-1:0] bins_sm [0:255];

  histogram_sched #(.N_PIXELS(NB), .BIN_W(BW)) u_big (
    .clk(clk), .rst(rst_bg), .start(start_bg), .busy(busy_bg), .valid(valid_bg),
    .arg_0_raddr_0(ra0_bg), .arg_0_rdata_0(rd0_bg), .arg_1_raddr_0(ra1_bg),
    .arg_1_rdata_0(rd1_bg), .arg_1_waddr_0(wa_bg), .arg_1_wdata_0(wd_bg),
    .arg_1_wen_0(we_bg), .stall_cnt(sc_bg));

  histogram_sched #(.N_PIXELS(NS), .BIN_W(BW)) u_small (
    .clk(clk), .rst(rst_sm), .start(start_sm), .busy(busy_sm), .valid(valid_sm),
    .arg_0_raddr_0(ra0_sm), .arg_0_rdata_0(rd0_sm), .arg_1_raddr_0(ra1_sm),
    .arg_1_rdata_0(rd1_sm), .arg_1_waddr_0(wa_sm), .arg_1_wdata_0(wd_sm),
    .arg_1_wen_0(we_sm), .stall_cnt(sc_sm));

  // Synchronous RAMs, read-before-write on collision
  always @(posedge clk) begin
    rd0_bg <= img_bg[ra0_bg];
    rd1_bg <= bins_bg[ra1_bg];
    if (we_bg) bins_bg[wa_bg] <= wd_bg;
  end

  always @(posedge clk) begin
    rd0_sm <= img_sm[ra0_sm[1:0]];
    rd1_sm <= bins_sm[ra1_sm];
    if (we_sm) bins_sm[wa_sm] <= wd_sm;
    if (pre_sm) bins_sm[8'd9] <= '1;
  end

  logic          busy_x, valid_x, we_x;
  logic [11:0]   ra0_x;
  logic [7:0]    ra1_x, wa_x;
  logic [BW-1:0] wd_x;
  logic [15:0]   sc_x;
  assign busy_x  = sel_big ? busy_bg  : busy_sm;
  assign valid_x = sel_big ? valid_bg : valid_sm;
  assign we_x    = sel_big ? we_bg    : we_sm;
  assign ra0_x   = sel_big ? ra0_bg   : ra0_sm;
  assign ra1_x   = sel_big ? ra1_bg   : ra1_sm;
  assign wa_x    = sel_big ? wa_bg    : wa_sm;
  assign wd_x    = sel_big ? wd_bg    : wd_sm;
  assign sc_x    = sel_big ? sc_bg    : sc_sm;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel_big) start_bg = v;
    else         start_sm = v;
  endtask

  // Model: one stall per pair of consecutive pixels in the same bin (none when forwarding)
  function automatic int model_stalls();
    int s;
    s = 0;
    if (!FWD) begin
      if (sel_big) begin
        for (int i = 1; i < NB; i++) if (img_bg[i] == img_bg[i-1]) s++;
      end else begin
        for (int i = 1; i < NS; i++) if (img_sm[i] == img_sm[i-1]) s++;
      end
    end
    return s;
  endfunction

  task automatic check_bins(input string tag);
    int unsigned hist [256];
    for (int k = 0; k < 256; k++) hist[k] = 0;
    if (sel_big) for (int i = 0; i < NB; i++) hist[img_bg[i]]++;
    else         for (int i = 0; i < NS; i++) hist[img_sm[i]]++;
    for (int k = 0; k < 256; k++)
      check($sformatf("%s bin%0d", tag, k), sel_big ? bins_bg[k] : bins_sm[k], hist[k]);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (valid_x !== 1'b1 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Start one run and check its length, end status and stall count
  task automatic run_job(input string tag);
    int cyc;
    int n;
    int st;
    n  = sel_big ? NB : NS;
    st = model_stalls();
    @(negedge clk); set_start(1'b1);
    @(posedge clk); #1; set_start(1'b0);
    check({tag, " busy"}, 32'(busy_x), 32'd1);
    wait_valid(cyc);
    check({tag, " cycles"}, 32'(cyc), 32'(256 + n + 2 + st));
    check({tag, " busy_done"}, 32'(busy_x), 32'd0);
    check({tag, " stall_cnt"}, 32'(sc_x), 32'(st));
    check_bins(tag);
  endtask

  initial begin
    int cyc;
    logic [BW-1:0] wrap_exp;
    rst_bg = 1'b0; rst_sm = 1'b0; start_bg = 1'b0; start_sm = 1'b0;
    pre_sm = 1'b0; sel_big = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("rst busy", 32'(busy_x), 32'd0);
    check("rst valid", 32'(valid_x), 32'd0);
    check("rst wen", 32'(we_x), 32'd0);
    check("rst raddr0", 32'(ra0_x), 32'd0);
    check("rst raddr1", 32'(ra1_x), 32'd0);
    check("rst waddr", 32'(wa_x), 32'd0);
    check("rst wdata", wd_x, 32'd0);
    check("rst stall_cnt", 32'(sc_x), 32'd0);
    check("rst small wen", 32'(we_sm), 32'd0);
    check("rst small raddr0", 32'(ra0_sm), 32'd0);
    @(negedge clk); rst_bg = 1'b1; rst_sm = 1'b1;

    // Big instance: all zeros, ramp, random full range, random narrow range
    for (int i = 0; i < NB; i++) img_bg[i] = 8'd0;
    run_job("zeros");
    repeat (3) @(posedge clk); #1;
    check("done valid held", 32'(valid_x), 32'd1);
    check("done wen", 32'(we_x), 32'd0);
    for (int i = 0; i < NB; i++) img_bg[i] = 8'(i % 256);
    run_job("ramp");
    for (int i = 0; i < NB; i++) img_bg[i] = 8'($urandom_range(255, 0));
    run_job("rand_full");
    for (int i = 0; i < NB; i++) img_bg[i] = 8'($urandom_range(3, 0));
    run_job("rand_narrow");

    // Reset in the middle of accumulation, then rerun
    for (int i = 0; i < NB; i++) img_bg[i] = 8'($urandom_range(7, 0));
    @(negedge clk); start_bg = 1'b1;
    @(posedge clk); #1; start_bg = 1'b0;
    cyc = 0;
    while (!(ra0_x == 12'd100 && busy_x) && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort at px100", 32'(ra0_x), 32'd100);
    rst_bg = 1'b0; #1;
    check("abort busy", 32'(busy_x), 32'd0);
    check("abort wen", 32'(we_x), 32'd0);
    check("abort valid", 32'(valid_x), 32'd0);
    check("abort raddr0", 32'(ra0_x), 32'd0);
    check("abort stall_cnt", 32'(sc_x), 32'd0);
    @(negedge clk); rst_bg = 1'b1;
    run_job("rerun");

    // Small instance: directed hazards
    sel_big = 1'b0;
    img_sm[0] = 8'd5; img_sm[1] = 8'd5; img_sm[2] = 8'd5; img_sm[3] = 8'd7;
    run_job("p5557");

    // Wrap-around: bin 9 preloaded to all-ones just after the clearing sweep
    img_sm[0] = 8'd9; img_sm[1] = 8'd9; img_sm[2] = 8'd3; img_sm[3] = 8'd3;
    @(negedge clk); start_sm = 1'b1;
    @(posedge clk); #1; start_sm = 1'b0;
    repeat (256) @(posedge clk);
    #1 pre_sm = 1'b1;
    @(posedge clk); #1 pre_sm = 1'b0;
    wait_valid(cyc);
    check("wrap valid", 32'(valid_x), 32'd1);
    wrap_exp = '1;
    wrap_exp = wrap_exp + 32'd2;
    check("wrap bin9", bins_sm[9], wrap_exp);
    check("wrap bin3", bins_sm[3], 32'd2);
    run_job("wrap_recleared");

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NS; i++) img_sm[i] = 8'($urandom_range(2, 0));
      run_job($sformatf("rand_small%0d", r));
    end

    // start held high: no restart while busy, one DONE cycle, then restart
    img_sm[0] = 8'd1; img_sm[1] = 8'd1; img_sm[2] = 8'd200; img_sm[3] = 8'd1;
    @(negedge clk); start_sm = 1'b1;
    @(posedge clk); #1;
    check("hold busy", 32'(busy_x), 32'd1);
    wait_valid(cyc);
    check("hold cycles", 32'(cyc), 32'(256 + NS + 2 + model_stalls()));
    @(posedge clk); #1;
    check("hold valid one cycle", 32'(valid_x), 32'd0);
    check("hold restart busy", 32'(busy_x), 32'd1);
    start_sm = 1'b0;
    wait_valid(cyc);
    check("hold second cycles", 32'(cyc), 32'(256 + NS + 2 + model_stalls()));
    check_bins("hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
